// File: rtl/alu32_arbiter.sv
// alu32_arbiter: two-requester arbiter/sequencer for the shared 32-bit ALU.
// One operation at a time: IDLE accepts a request and latches its operands,
// EXEC drives the ALU from the latched registers and captures the result, and
// RESP returns the result to the requester that issued the operation.
//
// Handshake rule (all channels): a transfer happens on the rising edge where
// valid and ready are both high. reqN_ready is a combinational function of
// state, priority and the req valids. respN_valid depends on state only.
//
// Build option: define ALU32_ARB_FIXED_PRIO_EN for fixed priority, where
// requester 0 always wins simultaneous requests and no priority pointer exists.
// The default build is round-robin.
module alu32_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_gnt_id;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_prio;
    logic             w_any_req;
    logic             w_grant_id;
    logic             w_accept;
    logic             w_resp_done;

    assign w_any_req = req0_valid | req1_valid;

    // Contention goes to the priority pointer; otherwise the lone requester wins.
    assign w_grant_id = (req0_valid & req1_valid) ? w_prio : req1_valid;

    // Reset is included so no ready is ever seen while the block is held in reset.
    assign w_accept = (r_state == S_IDLE) & w_any_req & ~reset;

    assign w_resp_done = (r_state == S_RESP) & (r_gnt_id ? resp1_ready : resp0_ready);

`ifdef ALU32_ARB_FIXED_PRIO_EN
    assign w_prio = 1'b0;
`else
    logic r_prio;

    // Round-robin pointer: after a completed response, favour the other requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (w_resp_done) begin
            r_prio <= ~r_gnt_id;
        end
    end

    assign w_prio = r_prio;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on take.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (w_resp_done) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: ready only for the granted requester in IDLE, valid only in RESP.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        if (w_accept) begin
            req0_ready = ~w_grant_id;
            req1_ready = w_grant_id;
        end
        if (r_state == S_RESP) begin
            resp0_valid = ~r_gnt_id;
            resp1_valid = r_gnt_id;
        end
        busy      = (r_state != S_IDLE);
        dbg_state = r_state;
    end

    // Operand latch on accept; these registers also hold the ALU inputs steady outside EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt_id <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else if (w_accept) begin
            r_gnt_id <= w_grant_id;
            r_op     <= w_grant_id ? req1_op : req0_op;
            r_a      <= w_grant_id ? req1_a  : req0_a;
            r_b      <= w_grant_id ? req1_b  : req0_b;
        end
    end

    // Result capture at the end of EXEC; held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_result <= alu_result;
            r_zero   <= (alu_result == '0);
        end
    end

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_sel     = r_op;
    assign resp_result = r_result;
    assign resp_zero   = r_zero;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Testbench for alu32_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_alu32_arbiter;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp0_valid, resp1_valid;
    logic         resp0_ready, resp1_ready;
    logic [W-1:0] resp_result;
    logic         resp_zero;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_result;
    logic         busy;
    logic [1:0]   dbg_state;

    alu32_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- ALU stand-in ----------------
    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    alu_fn = a & b;
            3'd1:    alu_fn = a | b;
            3'd2:    alu_fn = a ^ b;
            3'd3:    alu_fn = a + b;
            3'd4:    alu_fn = a - b;
            3'd5:    alu_fn = a << b[4:0];
            3'd6:    alu_fn = a >> b[4:0];
            default: alu_fn = (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One operation in flight at most. m_exec_done marks that the ALU cycle
    // has passed, so the result is owed to requester m_id.
    logic         m_active = 1'b0;
    logic         m_exec_done = 1'b0;
    logic         m_id = 1'b0;
    logic         m_pref = 1'b0;
    logic [2:0]   m_op = '0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] exp_q[$];

    logic e_acc, e_gid;
    assign e_acc = !m_active && (req0_valid || req1_valid) && !reset;
    assign e_gid = (req0_valid && req1_valid) ? m_pref : req1_valid;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active    <= 1'b0;
            m_exec_done <= 1'b0;
            m_id        <= 1'b0;
            m_pref      <= 1'b0;
            m_op        <= '0;
            m_a         <= '0;
            m_b         <= '0;
            exp_q.delete();
        end else if (!m_active) begin
            if (e_acc) begin
                m_active    <= 1'b1;
                m_exec_done <= 1'b0;
                m_id        <= e_gid;
                m_op        <= e_gid ? req1_op : req0_op;
                m_a         <= e_gid ? req1_a : req0_a;
                m_b         <= e_gid ? req1_b : req0_b;
                exp_q.push_back(e_gid ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b));
            end
        end else if (!m_exec_done) begin
            m_exec_done <= 1'b1;
        end else if (m_id ? resp1_ready : resp0_ready) begin
            m_active <= 1'b0;
            void'(exp_q.pop_front());
`ifndef ALU32_ARB_FIXED_PRIO_EN
            m_pref <= !m_id;
`endif
        end
    end

    // ---------------- per-cycle compare + grant log ----------------
    int g_id[$];
    int g_cyc[$];

    always @(negedge clk) begin
        check("req0_ready", req0_ready, e_acc && !e_gid);
        check("req1_ready", req1_ready, e_acc && e_gid);
        check("resp0_valid", resp0_valid, m_active && m_exec_done && !m_id);
        check("resp1_valid", resp1_valid, m_active && m_exec_done && m_id);
        check("busy", busy, m_active);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_sel", alu_sel, m_op);
        if (m_active && m_exec_done && exp_q.size() > 0) begin
            check("resp_result", resp_result, exp_q[0]);
            check("resp_zero", resp_zero, exp_q[0] == '0);
        end
        if (reset) begin
            check("rst_resp_result", resp_result, 0);
            check("rst_resp_zero", resp_zero, 0);
        end
        if (req0_ready) begin
            g_id.push_back(0);
            g_cyc.push_back(cyc);
        end else if (req1_ready) begin
            g_id.push_back(1);
            g_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end at posedge+1 unless noted.
    task automatic start_req(input int id, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, output int acc_cyc);
        int n;
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        n = 0;
        @(negedge clk);
        while (!(id == 0 ? req0_ready : req1_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", n < 20, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    // Ends at the negedge of the first cycle the response is valid.
    task automatic wait_resp(input int id, output logic [W-1:0] res, output logic z, output int rsp_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!(id == 0 ? resp0_valid : resp1_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("resp_timeout", n < 20, 1);
        rsp_cyc = cyc;
        res     = resp_result;
        z       = resp_zero;
    endtask

    // Starts at a negedge during RESP.
    task automatic release_resp(input int id);
        if (id == 0) resp0_ready = 1'b1;
        else         resp1_ready = 1'b1;
        @(posedge clk);
        #1;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", busy, 0);
        @(posedge clk);
        #1;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] r;
        logic         z;
        int           c0, c1;
        int           exp_ids[4];

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single request, AND.
        start_req(0, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, c0);
        wait_resp(0, r, z, c1);
        check("single_latency", c1 - c0, 2);
        check("single_result", r, 32'hF000_F000);
        check("single_zero", z, 0);
        check("single_resp1_valid", resp1_valid, 0);
        release_resp(0);

        // Zero result from requester 1.
        start_req(1, 3'd0, 32'h0000_FFFF, 32'hFFFF_0000, c0);
        wait_resp(1, r, z, c1);
        check("zero_result", r, 32'h0);
        check("zero_flag", z, 1);
        release_resp(1);

        // Simultaneous requests with responses always taken.
        g_id.delete();
        g_cyc.delete();
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'h1; req0_b = 32'h2;
        req1_valid = 1'b1; req1_op = 3'd3; req1_a = 32'h10; req1_b = 32'h20;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        drain();
`ifdef ALU32_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 0, 1};
`endif
        check("sim_grant_count", g_id.size() >= 4, 1);
        if (g_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("sim_grant_id", g_id[i], exp_ids[i]);
                if (i > 0) check("sim_grant_spacing", g_cyc[i] - g_cyc[i-1], 3);
            end
        end

        // Response backpressure; ADD wraps to zero at 32 bits.
        start_req(0, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, c0);
        req1_valid = 1'b1; req1_op = 3'd2; req1_a = 32'h1234_5678; req1_b = 32'h0F0F_0F0F;
        wait_resp(0, r, z, c1);
        check("wrap_result", r, 32'h0);
        check("wrap_zero", z, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp0_valid", resp0_valid, 1);
            check("bp_result_stable", resp_result, r);
            check("bp_req1_ready", req1_ready, 0);
        end
        release_resp(0);
        @(negedge clk);
        check("bp_idle_after", busy, 0);
        check("bp_req1_accept", req1_ready, 1);
        c0 = cyc;
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_resp(1, r, z, c1);
        check("bp_req1_latency", c1 - c0, 2);
        check("bp_req1_result", r, 32'h1D3B_5977);
        release_resp(1);

        // Reset while EXEC is in progress.
        start_req(1, 3'd1, 32'hAAAA_0000, 32'h0000_5555, c0);
        reset = 1'b1;
        #1;
        check("rexec_busy", busy, 0);
        check("rexec_alu_a", alu_a, 0);
        check("rexec_alu_b", alu_b, 0);
        check("rexec_alu_sel", alu_sel, 0);
        check("rexec_result", resp_result, 0);
        check("rexec_outs", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_zero}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rexec_no_resp", {resp0_valid, resp1_valid}, 0);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'h3; req0_b = 32'h5;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'h7; req1_b = 32'h9;
        @(negedge clk);
        check("rexec_grant0", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk);
        #1;
        drain();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
            end
            req0_valid  = ($urandom_range(0, 2) != 0);
            req1_valid  = ($urandom_range(0, 2) != 0);
            req0_op     = 3'($urandom_range(0, 7));
            req1_op     = 3'($urandom_range(0, 7));
            req0_a      = $urandom;
            req0_b      = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req1_a      = $urandom;
            req1_b      = ($urandom_range(0, 3) == 0) ? ~req1_a : $urandom;
            resp0_ready = ($urandom_range(0, 9) < 7);
            resp1_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
